// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with frame-level debounce and a one-cycle press strobe
module keypad_scanner #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_down
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB = CW'(DEBOUNCE);

    typedef enum logic {IDLE, PRESSED} state_t;
    typedef enum logic [1:0] {NONE, SINGLE, MULTI} cls_t;

    logic [3:0]      meta_q, col_q;
    logic [DW-1:0]   div_q, div_d;
    logic [1:0]      r_q, r_d;
    logic [2:0][3:0] acc_q, acc_d;
    cls_t            last_cls_q, last_cls_d, cls;
    logic [3:0]      last_code_q, last_code_d, code;
    logic [CW-1:0]   stable_q, stable_d;
    state_t          state_q, state_d;
    logic [3:0]      key_q, key_d;
    logic            key_valid_q, key_valid_d;
    logic [15:0]     map;
    logic            sample, frame_end, same;

    always_comb begin
        sample = div_q == DIV_MAX;
        frame_end = sample && r_q == 2'd3;
        div_d = sample ? '0 : div_q + 1'b1;
        r_d = sample ? r_q + 2'd1 : r_q;
        for (int i = 0; i < 3; i++) acc_d[i] = (sample && r_q == 2'(i)) ? ~col_q : acc_q[i];
        // row 3 is classified straight from the live sample, so it never needs a slot
        map = {~col_q, acc_q};
        cls = map == '0 ? NONE : $countones(map) == 1 ? SINGLE : MULTI;
        code = '0;
        for (int i = 0; i < 16; i++) if (cls == SINGLE && map[i]) code = 4'(i);
        same = cls == last_cls_q && code == last_code_q;
        last_cls_d = frame_end ? cls : last_cls_q;
        last_code_d = frame_end ? code : last_code_q;
        stable_d = !frame_end ? stable_q : !same ? CW'(1) : stable_q == DEB ? stable_q : stable_q + 1'b1;
        key_valid_d = frame_end && state_q == IDLE && cls == SINGLE && stable_d == DEB;
        key_d = key_valid_d ? code : key_q;
        state_d = key_valid_d ? PRESSED :
                  (frame_end && state_q == PRESSED && cls == NONE && stable_d == DEB) ? IDLE : state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q      <= '1;
            col_q       <= '1;
            div_q       <= '0;
            r_q         <= '0;
            acc_q       <= '0;
            last_cls_q  <= NONE;
            last_code_q <= '0;
            stable_q    <= DEB;
            state_q     <= IDLE;
            key_q       <= '0;
            key_valid_q <= 1'b0;
        end else begin
            meta_q      <= col_n;
            col_q       <= meta_q;
            div_q       <= div_d;
            r_q         <= r_d;
            acc_q       <= acc_d;
            last_cls_q  <= last_cls_d;
            last_code_q <= last_code_d;
            stable_q    <= stable_d;
            state_q     <= state_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign row_n     = ~(4'b0001 << r_q);
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign key_down  = state_q == PRESSED;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model, frame table, directed corner cases and randomized frames
module tb_keypad_scanner;
    localparam int SD  = 4;
    localparam int DEB = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col_n, row_n, key;
    logic        key_valid, key_down;
    logic [15:0] held = '0;

    always #5 clk = ~clk;

    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row_n[r] && held[r*4+c]) col_n[c] = 1'b0;
    end

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .col_n(col_n), .row_n(row_n),
        .key(key), .key_valid(key_valid), .key_down(key_down)
    );

    typedef struct {
        logic [15:0] m;
        logic        v;
        logic [3:0]  k;
        logic        d;
    } vec_t;
    vec_t tbl [18];

    int n_chk = 0, n_pass = 0, cyc = 0;
    logic ev = 1'b0, ed = 1'b0;
    logic [3:0] ek = '0;
    int m_last, m_cnt;
    bit m_pr;

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    endtask

    task automatic model_reset();
        m_last = -1;
        m_cnt = DEB;
        m_pr = 0;
        ev = 1'b0;
        ek = '0;
        ed = 1'b0;
    endtask

    // frame-level reference: -1 none, 0..15 single key, 16 multiple keys
    task automatic model_frame(input logic [15:0] m);
        int n, res;
        n = $countones(m);
        res = 16;
        if (n == 0) res = -1;
        else if (n == 1) for (int i = 0; i < 16; i++) if (m[i]) res = i;
        if (res == m_last) m_cnt = (m_cnt < DEB) ? m_cnt + 1 : DEB;
        else begin
            m_last = res;
            m_cnt = 1;
        end
        ev = 1'b0;
        if (!m_pr && res >= 0 && res < 16 && m_cnt == DEB) begin
            m_pr = 1;
            ek = 4'(res);
            ev = 1'b1;
        end else if (m_pr && res < 0 && m_cnt == DEB) m_pr = 0;
        ed = m_pr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        chk("row_n", row_n, ~(4'b0001 << ((cyc / 4) % 4)));
    endtask

    task automatic run_frame(input logic [15:0] m, input bit use_tbl, input vec_t v);
        held = m;
        for (int i = 0; i < 4 * SD; i++) begin
            tick();
            ev = 1'b0;
            if (i == 4 * SD - 1) begin
                if (use_tbl) begin
                    ev = v.v;
                    ek = v.k;
                    ed = v.d;
                end else model_frame(m);
            end
            chk("key_valid", {3'b0, key_valid}, {3'b0, ev});
            chk("key", key, ek);
            chk("key_down", {3'b0, key_down}, {3'b0, ed});
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_row_n", row_n, 4'b1110);
        chk("rst_key", key, 4'h0);
        chk("rst_key_valid", {3'b0, key_valid}, 4'h0);
        chk("rst_key_down", {3'b0, key_down}, 4'h0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        model_reset();
    endtask

    initial begin
        int pulses_b, pulses_s, sel, a, b, reps;
        logic [3:0] kseen;
        logic [15:0] m;
        tbl[0]  = '{16'h0000, 1'b0, 4'd0,  1'b0};
        tbl[1]  = '{16'h0200, 1'b0, 4'd0,  1'b0};
        tbl[2]  = '{16'h0200, 1'b1, 4'd9,  1'b1};
        tbl[3]  = '{16'h0200, 1'b0, 4'd9,  1'b1};
        tbl[4]  = '{16'h0000, 1'b0, 4'd9,  1'b1};
        tbl[5]  = '{16'h0000, 1'b0, 4'd9,  1'b0};
        tbl[6]  = '{16'h4010, 1'b0, 4'd9,  1'b0};
        tbl[7]  = '{16'h4010, 1'b0, 4'd9,  1'b0};
        tbl[8]  = '{16'h0010, 1'b0, 4'd9,  1'b0};
        tbl[9]  = '{16'h0010, 1'b1, 4'd4,  1'b1};
        tbl[10] = '{16'h0410, 1'b0, 4'd4,  1'b1};
        tbl[11] = '{16'h0410, 1'b0, 4'd4,  1'b1};
        tbl[12] = '{16'h0000, 1'b0, 4'd4,  1'b1};
        tbl[13] = '{16'h0000, 1'b0, 4'd4,  1'b0};
        tbl[14] = '{16'h0400, 1'b0, 4'd4,  1'b0};
        tbl[15] = '{16'h0400, 1'b1, 4'd10, 1'b1};
        tbl[16] = '{16'h0008, 1'b0, 4'd10, 1'b1};
        tbl[17] = '{16'h0008, 1'b0, 4'd10, 1'b1};

        repeat (2) @(posedge clk);
        #2;
        check_reset_vals();
        release_reset();
        for (int f = 0; f < 10; f++) run_frame(16'h0000, 1'b0, tbl[0]);
        for (int i = 0; i < 18; i++) run_frame(tbl[i].m, 1'b1, tbl[i]);

        repeat (6) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        release_reset();
        for (int f = 0; f < 3; f++) run_frame(16'h0008, 1'b0, tbl[0]);
        for (int f = 0; f < 2; f++) run_frame(16'h0000, 1'b0, tbl[0]);

        pulses_b = 0;
        pulses_s = 0;
        kseen = '0;
        for (int t = 0; t < 3 * 4 * SD; t++) begin
            held = ((t / 5) % 2 == 0) ? 16'h0008 : 16'h0000;
            tick();
            if (key_valid) pulses_b++;
        end
        held = 16'h0008;
        for (int t = 0; t < (DEB + 1) * 4 * SD + 3; t++) begin
            tick();
            if (key_valid) begin
                pulses_s++;
                kseen = key;
            end
        end
        chk("bounce_strobes", 4'(pulses_b), 4'd0);
        chk("steady_strobes", 4'(pulses_s), 4'd1);
        chk("steady_key", kseen, 4'd3);

        @(posedge clk);
        #1;
        rst_n = 1'b0;
        held = '0;
        #2;
        check_reset_vals();
        release_reset();
        for (int f = 0; f < 90; f += reps) begin
            sel = $urandom_range(0, 9);
            a = $urandom_range(0, 15);
            b = (a + $urandom_range(1, 15)) % 16;
            m = (sel < 4) ? 16'h0000 : (sel < 8) ? (16'h0001 << a) : ((16'h0001 << a) | (16'h0001 << b));
            reps = $urandom_range(1, 3);
            for (int j = 0; j < reps; j++) run_frame(m, 1'b0, tbl[0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
